// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes, datapath selects.
package cu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALU_WB = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_UTYPE  = 4'd10,
    S_JALR   = 4'd11,
    S_EXEC_I = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States whose exit to FETCH completes an instruction.
  function automatic logic retires(state_t s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALU_WB) ||
           (s == S_BRANCH) || (s == S_JAL) || (s == S_JALR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit bundle: opcode/memory handshake in, datapath strobes and status out.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       MemtoReg;
  logic [1:0]       PCSource;
  logic [1:0]       ALUOp;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [3:0]       currentState;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, currentState, illegal, instret
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, currentState, illegal, instret
  );
endinterface

// File: rtl/cu_next_state.sv
// Next-state decode for the multicycle control FSM; i_ready is the already-qualified handshake.
module cu_next_state
  import cu_pkg::*;
#(
  parameter bit ENABLE_TRAP = 1'b1
) (
  input  state_t     i_state,
  input  logic [6:0] i_op,
  input  logic       i_ready,
  output state_t     o_next
);

  always_comb begin
    o_next = S_FETCH;
    case (i_state)
      S_FETCH:  o_next = i_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op)
          OP_LOAD, OP_STORE: o_next = S_MEMADR;
          OP_RTYPE:          o_next = S_EXEC_R;
          OP_ITYPE:          o_next = S_EXEC_I;
          OP_BRANCH:         o_next = S_BRANCH;
          OP_JAL:            o_next = S_JAL;
          OP_JALR:           o_next = S_JALR;
          OP_LUI, OP_AUIPC:  o_next = S_UTYPE;
          default:           o_next = ENABLE_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: o_next = (i_op == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  o_next = i_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  o_next = i_ready ? S_FETCH : S_MEMWR;
      S_EXEC_R, S_EXEC_I, S_UTYPE: o_next = S_ALU_WB;
      S_TRAP:   o_next = S_TRAP;
      default:  o_next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: state register, retired-instruction counter, Moore output decode.
//   state  | meaning
//   FETCH  | read instruction, PC+4 on mem_ready
//   DECODE | ALUOut = OldPC+imm, dispatch on op
//   MEMADR | address = rs1+imm
//   MEMRD  | data read, wait mem_ready
//   MEMWB  | load write-back
//   MEMWR  | data write, wait mem_ready
//   EXEC_R | R-type ALU
//   EXEC_I | I-type ALU
//   UTYPE  | LUI/AUIPC ALU
//   ALU_WB | ALU result write-back
//   BRANCH | conditional PC update
//   JAL    | jump and link
//   JALR   | indirect jump and link
//   TRAP   | illegal opcode, held until reset
module multicycle_ctrl_fsm
  import cu_pkg::*;
#(
  parameter bit MEM_WAIT    = 1'b1,
  parameter bit ENABLE_TRAP = 1'b1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_is_lui;
  logic [CNT_W-1:0] r_instret;
  logic             w_ready;

  assign w_ready = MEM_WAIT ? bus.mem_ready : 1'b1;

  cu_next_state #(.ENABLE_TRAP(ENABLE_TRAP)) u_next (
    .i_state (r_state),
    .i_op    (bus.op),
    .i_ready (w_ready),
    .o_next  (w_next)
  );

  // LUI vs AUIPC is latched in DECODE so UTYPE never looks at op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_is_lui  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (retires(r_state) && (w_next == S_FETCH))
        r_instret <= r_instret + CNT_W'(1);
      if (r_state == S_DECODE)
        r_is_lui <= (bus.op == OP_LUI);
    end
  end

  assign bus.currentState = r_state;
  assign bus.illegal      = (r_state == S_TRAP);
  assign bus.instret      = r_instret;

  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemtoReg    = M2R_ALUOUT;
    bus.PCSource    = PCS_ALU;
    bus.ALUOp       = ALUOP_ADD;
    bus.ALUSrcA     = SRCA_PC;
    bus.ALUSrcB     = SRCB_RS2;
    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.IRWrite = w_ready;
        bus.PCWrite = w_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = M2R_MDR;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        bus.ALUOp   = ALUOP_R;
      end
      S_EXEC_I: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_I;
      end
      S_UTYPE: begin
        bus.ALUSrcA = r_is_lui ? SRCA_ZERO : SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_ALU_WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = M2R_ALUOUT;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = SRCA_RS1;
        bus.ALUSrcB     = SRCB_RS2;
        bus.ALUOp       = ALUOP_BR;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = PCS_BRANCH;
      end
      S_JAL: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_JUMP;
        bus.RegWrite = 1'b1;
        bus.MemtoReg = M2R_PC;
      end
      S_JALR: begin
        bus.ALUSrcA  = SRCA_RS1;
        bus.ALUSrcB  = SRCB_IMM;
        bus.PCWrite  = 1'b1;
        bus.PCSource = PCS_ALU;
        bus.RegWrite = 1'b1;
        bus.MemtoReg = M2R_PC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench: two builds (default, and MEM_WAIT=0/ENABLE_TRAP=0/CNT_W=2) against an instruction-level model.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111, IL = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic       rdy;
  logic [6:0] op;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         chk_en = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.CNT_W(32)) bus0 ();
  multicycle_ctrl_fsm_if #(.CNT_W(2))  bus1 ();

  assign bus0.op = op;
  assign bus0.mem_ready = rdy;
  assign bus1.op = op;
  assign bus1.mem_ready = rdy;

  multicycle_ctrl_fsm #(.MEM_WAIT(1'b1), .ENABLE_TRAP(1'b1), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .bus(bus0));
  multicycle_ctrl_fsm #(.MEM_WAIT(1'b0), .ENABLE_TRAP(1'b0), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .bus(bus1));

  logic [16:0] act0, act1;
  assign act0 = {bus0.PCWrite, bus0.PCWriteCond, bus0.IorD, bus0.MemRead, bus0.MemWrite,
                 bus0.IRWrite, bus0.RegWrite, bus0.MemtoReg, bus0.PCSource, bus0.ALUOp,
                 bus0.ALUSrcA, bus0.ALUSrcB};
  assign act1 = {bus1.PCWrite, bus1.PCWriteCond, bus1.IorD, bus1.MemRead, bus1.MemWrite,
                 bus1.IRWrite, bus1.RegWrite, bus1.MemtoReg, bus1.PCSource, bus1.ALUOp,
                 bus1.ALUSrcA, bus1.ALUSrcB};

  // Instruction-level model: each decoded instruction becomes a short plan of steps.
  int          m_st[2]  = '{0, 0};
  int          m_plan[2][3];
  int          m_len[2] = '{0, 0};
  int          m_pos[2] = '{0, 0};
  logic [31:0] m_ret[2] = '{0, 0};
  bit          m_lui[2] = '{0, 0};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic advance(input int d);
    if (m_pos[d] < m_len[d]) begin
      m_st[d] = m_plan[d][m_pos[d]];
      m_pos[d]++;
    end else begin
      m_st[d] = 0;
      m_ret[d] = (m_ret[d] + 1) & ((d == 1) ? 32'h3 : 32'hFFFF_FFFF);
    end
  endtask

  task automatic model_step(input int d);
    bit rd;
    rd = rdy || (d == 1);
    if (reset) begin
      m_st[d] = 0; m_len[d] = 0; m_pos[d] = 0; m_ret[d] = 0; m_lui[d] = 0;
    end else begin
      case (m_st[d])
        13: ;
        0: if (rd) m_st[d] = 1;
        1: begin
          m_lui[d] = (op == LU);
          m_pos[d] = 0;
          m_len[d] = 1;
          case (op)
            LD, ST: m_plan[d][0] = 2;
            RT: begin m_plan[d][0] = 6; m_plan[d][1] = 7; m_len[d] = 2; end
            IT: begin m_plan[d][0] = 12; m_plan[d][1] = 7; m_len[d] = 2; end
            LU, AU: begin m_plan[d][0] = 10; m_plan[d][1] = 7; m_len[d] = 2; end
            BR: m_plan[d][0] = 8;
            JL: m_plan[d][0] = 9;
            JR: m_plan[d][0] = 11;
            default: begin m_plan[d][0] = 13; m_len[d] = (d == 0) ? 1 : 0; end
          endcase
          if (m_len[d] == 0) m_st[d] = 0;
          else advance(d);
        end
        2: begin
          m_pos[d] = 0;
          if (op == ST) begin m_st[d] = 5; m_len[d] = 0; end
          else begin m_st[d] = 3; m_plan[d][0] = 4; m_len[d] = 1; end
        end
        3, 5: if (rd) advance(d);
        default: advance(d);
      endcase
    end
  endtask

  function automatic logic [16:0] exp_out(input int st, input bit rd, input bit lui);
    logic pcw, pcc, iord, mrd, mwr, irw, rgw;
    logic [1:0] m2r, pcs, aop, sa, sb;
    {pcw, pcc, iord, mrd, mwr, irw, rgw} = '0;
    {m2r, pcs, aop, sa, sb} = '0;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = rd; pcw = rd; end
      1:  begin sa = 2'b10; sb = 2'b10; end
      2:  begin sa = 2'b01; sb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rgw = 1; m2r = 2'b01; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin sa = 2'b01; aop = 2'b10; end
      7:  rgw = 1;
      8:  begin sa = 2'b01; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; rgw = 1; m2r = 2'b10; end
      10: begin sb = 2'b10; sa = lui ? 2'b11 : 2'b10; end
      11: begin sa = 2'b01; sb = 2'b10; pcw = 1; rgw = 1; m2r = 2'b10; end
      12: begin sa = 2'b01; sb = 2'b10; aop = 2'b11; end
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, rgw, m2r, pcs, aop, sa, sb};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("d0_state",   bus0.currentState, m_st[0]);
      cmp("d0_outs",    act0, exp_out(m_st[0], rdy, m_lui[0]));
      cmp("d0_illegal", bus0.illegal, (m_st[0] == 13));
      cmp("d0_instret", bus0.instret, m_ret[0]);
      cmp("d1_state",   bus1.currentState, m_st[1]);
      cmp("d1_outs",    act1, exp_out(m_st[1], 1'b1, m_lui[1]));
      cmp("d1_illegal", bus1.illegal, (m_st[1] == 13));
      cmp("d1_instret", bus1.instret, m_ret[1]);
    end
  end

  // Clock edge, model update, then drive the inputs seen until the next edge.
  task automatic apply(input bit r, input bit rd, input logic [6:0] o);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    reset = r; rdy = rd; op = o;
  endtask

  typedef struct { bit r; bit rd; logic [6:0] o; int st; } dir_t;
  dir_t dtab[$];

  task automatic add(input bit r, input bit rd, input logic [6:0] o, input int st);
    dir_t e;
    e.r = r; e.rd = rd; e.o = o; e.st = st;
    dtab.push_back(e);
  endtask

  initial begin
    logic [6:0] vops[9];
    vops = '{LD, ST, RT, IT, BR, JL, JR, LU, AU};
    reset = 1'b1; rdy = 1'b0; op = '0;
    apply(1, 0, '0);
    chk_en = 1'b1;
    apply(0, 0, '0);
    @(negedge clk);
    cmp("lit_rst_state",   bus0.currentState, 0);
    cmp("lit_rst_memread", bus0.MemRead, 1);
    cmp("lit_rst_irwrite", bus0.IRWrite, 0);
    cmp("lit_rst_instret", bus0.instret, 0);

    add(0, 1, RT, 0); add(0, 1, RT, 1); add(0, 1, RT, 6); add(0, 1, RT, 7); add(0, 0, RT, 0);
    add(0, 0, LD, 0); add(0, 1, LD, 0); add(0, 1, LD, 1); add(0, 0, LD, 2);
    add(0, 0, LD, 3); add(0, 0, LD, 3); add(0, 0, LD, 3); add(0, 1, LD, 3);
    add(0, 1, LD, 4); add(0, 1, IL, 0); add(0, 1, IL, 1);
    for (int i = 0; i < 10; i++) add(0, 1, IL, 13);
    add(1, 0, '0, 13); add(0, 0, '0, 0);
    foreach (dtab[i]) begin
      apply(dtab[i].r, dtab[i].rd, dtab[i].o);
      @(negedge clk);
      cmp("lit_seq_state", bus0.currentState, dtab[i].st);
      cmp("lit_seq_illegal", bus0.illegal, (dtab[i].st == 13));
      cmp("lit_seq_regwrite", bus0.RegWrite, (dtab[i].st == 7 || dtab[i].st == 4));
      if (dtab[i].st == 0) cmp("lit_fetch_irwrite", bus0.IRWrite, dtab[i].rd);
      if (dtab[i].st == 3) cmp("lit_memrd_memread", bus0.MemRead, 1);
      if (i == 4)  cmp("lit_r_instret", bus0.instret, 1);
      if (i == 14) cmp("lit_ld_instret", bus0.instret, 2);
    end
    cmp("lit_trap_rst_instret", bus0.instret, 0);

    apply(0, 1, JL);
    for (int k = 1; k <= 5; k++) begin
      apply(0, 1, JL); apply(0, 1, JL); apply(0, 1, JL);
      @(negedge clk);
      cmp("lit_wrap_instret", bus1.instret, k % 4);
      cmp("lit_jal_instret", bus0.instret, k);
    end
    apply(0, 1, LD); apply(0, 0, LD); apply(0, 0, LD); apply(1, 0, LD);
    @(negedge clk);
    cmp("lit_wait_state", bus0.currentState, 3);
    apply(0, 0, '0);
    @(negedge clk);
    cmp("lit_midwait_rst_state", bus0.currentState, 0);
    cmp("lit_midwait_rst_instret", bus0.instret, 0);

    for (int n = 0; n < 3000; n++) begin
      bit r, rd;
      logic [6:0] o;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 3) != 0);
      if ((m_st[0] == 1 || m_st[0] == 2 || m_st[1] == 1 || m_st[1] == 2) &&
          $urandom_range(0, 9) != 0)
        o = vops[$urandom_range(0, 8)];
      else
        o = 7'($urandom_range(0, 127));
      apply(r, rd, o);
    end
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 1, meaning: 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter ENABLE_TRAP, default 1, meaning: 1 = unknown opcode enters TRAP; 0 = unknown opcode returns to FETCH.
REQ-003 Parameter CNT_W, default 32, meaning: width of retired-instruction counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 op  in  7  opcode field of instruction register.
REQ-007 mem_ready  in  1  memory handshake; current access completes this cycle.
REQ-008 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes/selects.
REQ-009 MemtoReg  out  2  write-back select: 00 ALUOut, 01 MDR, 10 PC (link).
REQ-010 PCSource  out  2  00 ALU result, 01 ALUOut (taken branch), 10 ALUOut (jump).
REQ-011 ALUOp  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct.
REQ-012 ALUSrcA  out  2  00 PC, 01 rs1, 10 OldPC, 11 zero.
REQ-013 ALUSrcB  out  2  00 rs2, 01 constant 4, 10 immediate.
REQ-014 currentState  out  4  state register; illegal  out  1  high in TRAP; instret  out  CNT_W  retired count.

Function
REQ-015 States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, ALU_WB 7, BRANCH 8, JAL 9, UTYPE 10, JALR 11, EXEC_I 12, TRAP 13; codes 14-15 go to FETCH next cycle with all strobes 0.
REQ-016 Outputs are Moore functions of state, except strobes qualified by mem_ready (REQ-018); every output not listed for a state is 0.
REQ-017 FETCH: MemRead=1, ALUSrcA=00, ALUSrcB=01; IRWrite=PCWrite=1 only when mem_ready; advance to DECODE only when mem_ready.
REQ-018 MEMRD (MemRead=1, IorD=1) and MEMWR (MemWrite=1, IorD=1) hold until mem_ready; MEMRD->MEMWB, MEMWR->FETCH.
REQ-019 DECODE: ALUSrcA=10, ALUSrcB=10 (ALUOut=OldPC+imm); next by op: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR, 0110111/0010111->UTYPE, else TRAP (or FETCH per REQ-002).
REQ-020 MEMADR: ALUSrcA=01, ALUSrcB=10; load->MEMRD, store->MEMWR.
REQ-021 MEMWB: RegWrite=1, MemtoReg=01 -> FETCH.
REQ-022 EXEC_R: ALUSrcA=01, ALUSrcB=00, ALUOp=10 -> ALU_WB; EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11 -> ALU_WB.
REQ-023 UTYPE: ALUSrcB=10, ALUSrcA=11 for op 0110111, 10 for 0010111 -> ALU_WB; ALU_WB: RegWrite=1, MemtoReg=00 -> FETCH.
REQ-024 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
REQ-025 JAL: PCWrite=1, PCSource=10, RegWrite=1, MemtoReg=10 -> FETCH.
REQ-026 JALR: ALUSrcA=01, ALUSrcB=10, PCWrite=1, PCSource=00, RegWrite=1, MemtoReg=10 -> FETCH.
REQ-027 TRAP: illegal=1, all strobes 0, remains until reset.
REQ-028 instret increments by 1 on each transition into FETCH from MEMWB, MEMWR(ready), ALU_WB, BRANCH, JAL, JALR; wraps modulo 2^CNT_W; not incremented from TRAP or codes 14-15.
REQ-029 op sampled combinationally only in DECODE and MEMADR; op changes elsewhere have no effect.

Reset
REQ-030 reset high at a rising edge: state=FETCH, instret=0, illegal=0; takes priority over every transition, including mid-wait and TRAP.
REQ-031 While in FETCH after reset, outputs equal REQ-017 values (MemRead=1); no strobe fires before first post-reset edge.

Structure
REQ-032 State codes, opcode constants and select encodings live in shared package cu_pkg.
REQ-033 Next-state logic in one sub-module cu_next_state; outputs decoded in the top module.

Verification
REQ-034 R-type 0110011, mem_ready=1: states 0,1,6,7,0; RegWrite=1 only in state 7; instret 0->1.
REQ-035 Load 0000011, mem_ready low 3 cycles in MEMRD: state 3 held 4 cycles, MemRead=1 throughout, then 4,0; instret=1.
REQ-036 FETCH with mem_ready=0 for 2 cycles: IRWrite=PCWrite=0 both cycles, 1 on ready cycle; MEM_WAIT=0 build ignores mem_ready.
REQ-037 op=1111111: DECODE->TRAP, illegal=1, stays 10 cycles; reset -> FETCH, illegal=0; ENABLE_TRAP=0 build returns to FETCH.
REQ-038 CNT_W=2: 5 retired instructions -> instret 0,1,2,3,0,1; reset asserted in MEMRD wait -> FETCH next edge, instret=0.
